instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
Upstream instruction sequencer for the cpu block. Holds a program counter and reads 16-bit instructions from a synchronous instruction memory. Presents each instruction to the cpu on cpu_in with a one-cycle cpu_load pulse, then a one-cycle cpu_s pulse. Waits for the cpu's w handshake to complete before fetching the next instruction, and stops permanently on a HALT opcode.

Parameters:
ADDR_W, 8, program counter / memory address width
DATA_W, 16, instruction width
HALT_OP, 3'b111, opcode value in instr[15:13] that halts sequencing
PC_RESET, 0, program counter value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
go  input  1  start/continue execution request (level)
stop  input  1  stop after the current instruction completes (level)
mem_addr  output  ADDR_W  instruction memory address (equals pc)
mem_rd  output  1  memory read strobe; data valid on mem_rdata the following cycle
mem_rdata  input  DATA_W  instruction memory read data
cpu_in  output  DATA_W  instruction to the cpu (registered)
cpu_load  output  1  cpu instruction-register load pulse
cpu_s  output  1  cpu start pulse
cpu_w  input  1  cpu waiting/idle flag
pc  output  ADDR_W  current program counter
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
instr_count  output  16  completed-instruction counter, saturating

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. Reset values:
  - state=IDLE, pc=PC_RESET, cpu_in=0, instr_count=0.
  - cpu_load, cpu_s, mem_rd, busy, halted all 0.
- Reset asserted in any state, including mid-handshake, takes effect at the next edge. No further load/s pulses are issued.
- FSM states: IDLE, FETCH, CAPTURE, ISSUE, START, WAIT_ACK, WAIT_DONE, HALT.
- IDLE:
  - go=1 & stop=0 & cpu_w=1 -> FETCH.
  - stop has priority over go.
  - cpu_w=0 holds IDLE.
- FETCH: mem_rd=1, mem_addr=pc -> CAPTURE.
- CAPTURE: cpu_in <= mem_rdata.
  - If mem_rdata[15:13]==HALT_OP -> HALT. pc is not advanced and no load/s pulse is issued.
  - Otherwise -> ISSUE.
- ISSUE: cpu_load=1 for exactly one cycle, with cpu_in stable -> START.
- START: cpu_s=1 for exactly one cycle; pc <= pc+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00) -> WAIT_ACK.
- WAIT_ACK: waits for cpu_w==0 (cpu accepted) -> WAIT_DONE. There is no timeout.
- WAIT_DONE: waits for cpu_w==1. On that cycle:
  - instr_count increments, saturating at 16'hFFFF.
  - stop=1 or go=0 -> IDLE; otherwise -> FETCH.
- HALT: halted=1 and busy=0. go and stop are ignored. Only reset exits HALT.
- Latency: 4 cycles from leaving IDLE to the cpu_s pulse (FETCH, CAPTURE, ISSUE, START). Minimum per-instruction overhead beyond cpu execution is 4 cycles.
- Outputs:
  - cpu_load, cpu_s and mem_rd are decoded from state (Moore), with no glitch-dependent paths.
  - cpu_in changes only in CAPTURE.
- cpu_load and cpu_s are never asserted in the same cycle.

Decomposition:
- Shared package holds:
  - the state encoding (3-bit localparams for the 8 states);
  - the HALT_OP constant;
  - the opcode field position constants (15:13).
- One natural sub-module: fetch_pc.
  - Contains the PC register with synchronous reset to PC_RESET, an increment enable, and wrap-around.
  - Contains the saturating instr_count counter.

Test Plan:
- Reset then idle: assert reset 2 cycles with go=0 -> pc=0x00, cpu_in=0x0000, busy=0, halted=0, instr_count=0, and no strobes.
- Single instruction: mem[0]=16'hD105, go=1, model cpu drops w 1 cycle after s and raises it 3 cycles later -> cpu_load at cycle 3, cpu_s at cycle 4, cpu_in=0xD105, pc=1, instr_count=1, FETCH of address 1 follows.
- Halt: mem[0]=0xD105, mem[1]=0xE000 -> one load/s pair only, halted=1, pc=1, instr_count=1. go toggled for 10 cycles leaves halted=1.
- Stop mid-run: assert stop during WAIT_ACK of instruction at pc=2 -> that instruction completes, instr_count=3, then IDLE with pc=3 and no further mem_rd.
- Wrap and saturation: preload pc=0xFF (program of non-halt instructions) -> after START pc=0x00. Force instr_count=16'hFFFE, complete 2 instructions -> instr_count=16'hFFFF.
- Reset mid-handshake: assert reset in WAIT_DONE with cpu_w=0 -> next cycle state IDLE, pc=0, cpu_s=0, cpu_load=0, instr_count=0.

Source files
------------

// File: rtl/instr_fetch_seq_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq_pkg
// Shared definitions for the instruction fetch sequencer:
//   - state_t       : sequencer FSM state encoding (3 bits, 8 states)
//   - HALT_OPCODE   : default opcode value that stops sequencing
//   - OP_MSB/OP_LSB : position of the opcode field inside an instruction
//   - opcode_of()   : extracts the opcode field from a 16-bit instruction
// ----------------------------------------------------------------------------
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CAPTURE   = 3'd2,
    S_ISSUE     = 3'd3,
    S_START     = 3'd4,
    S_WAIT_ACK  = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 13;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  localparam logic [OP_W-1:0] HALT_OPCODE = 3'b111;

  function automatic logic [OP_W-1:0] opcode_of(input logic [15:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage : instr_fetch_seq_pkg

// File: rtl/instr_fetch_seq_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq_if
// Bus bundle between the fetch sequencer, the instruction memory and the cpu.
//   mem_addr  : instruction memory address (sequencer -> memory)
//   mem_rd    : memory read strobe, data valid on mem_rdata one cycle later
//   mem_rdata : instruction memory read data (memory -> sequencer)
//   cpu_in    : instruction presented to the cpu (registered)
//   cpu_load  : cpu instruction-register load pulse
//   cpu_s     : cpu start pulse
//   cpu_w     : cpu waiting/idle flag (cpu -> sequencer)
// Modports: master = sequencer side, slave = memory/cpu side.
// ----------------------------------------------------------------------------
interface instr_fetch_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] cpu_in;
  logic              cpu_load;
  logic              cpu_s;
  logic              cpu_w;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output cpu_in,
    output cpu_load,
    output cpu_s,
    input  cpu_w
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  cpu_in,
    input  cpu_load,
    input  cpu_s,
    output cpu_w
  );

endinterface : instr_fetch_seq_if

// File: rtl/instr_fetch_seq_fetch_pc.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq_fetch_pc
// Program counter and completed-instruction counter.
//   clk           : rising-edge clock
//   reset         : synchronous active-high reset
//   i_pc_inc      : advance the program counter by one (wraps at 2^ADDR_W)
//   i_count_inc   : one instruction completed; counter saturates at all-ones
//   o_pc          : current program counter
//   o_instr_count : completed-instruction count
// ----------------------------------------------------------------------------
module instr_fetch_seq_fetch_pc #(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pc_inc,
  input  logic              i_count_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [15:0]       o_instr_count
);

  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr_count;

  // Natural modulo-2^ADDR_W wrap from the fixed-width add.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PC_RESET;
    end else if (i_pc_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (i_count_inc && (r_instr_count != '1)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign o_pc          = r_pc;
  assign o_instr_count = r_instr_count;

endmodule : instr_fetch_seq_fetch_pc

// File: rtl/instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq
// Upstream instruction sequencer for the cpu. Reads instructions from a
// synchronous instruction memory at pc, presents each one on cpu_in with a
// one-cycle cpu_load pulse followed by a one-cycle cpu_s pulse, then waits for
// the cpu's w handshake (w falls, then rises) before fetching the next one.
// A HALT opcode stops sequencing until reset.
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   go          : start/continue request (level)
//   stop        : stop after the current instruction completes (level)
//   bus         : memory + cpu handshake bundle (master side)
//   pc          : current program counter (also drives mem_addr)
//   busy        : high in every state except IDLE and HALT
//   halted      : high in HALT
//   instr_count : completed-instruction counter, saturating
// ----------------------------------------------------------------------------
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [OP_W-1:0]   HALT_OP  = HALT_OPCODE,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                stop,
  instr_fetch_seq_if.master   bus,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         instr_count
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_cpu_in;

  logic w_mem_rd;
  logic w_capture;
  logic w_load;
  logic w_start;
  logic w_pc_inc;
  logic w_count_inc;
  logic w_is_halt;

  assign w_is_halt = (bus.mem_rdata[OP_MSB:OP_LSB] == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_rd    = 1'b0;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_pc_inc    = 1'b0;
    w_count_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // stop outranks go; only start when the cpu reports idle
        if (go && !stop && bus.cpu_w) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_mem_rd = 1'b1;
        w_next   = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = w_is_halt ? S_HALT : S_ISSUE;
      end
      S_ISSUE: begin
        w_load = 1'b1;
        w_next = S_START;
      end
      S_START: begin
        w_start  = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!bus.cpu_w) begin
          w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.cpu_w) begin
          w_count_inc = 1'b1;
          w_next      = (stop || !go) ? S_IDLE : S_FETCH;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Instruction register; loaded for HALT too, but never pulsed to the cpu.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_in <= '0;
    end else if (w_capture) begin
      r_cpu_in <= bus.mem_rdata;
    end
  end

  instr_fetch_seq_fetch_pc #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_fetch_pc (
    .clk           (clk),
    .reset         (reset),
    .i_pc_inc      (w_pc_inc),
    .i_count_inc   (w_count_inc),
    .o_pc          (pc),
    .o_instr_count (instr_count)
  );

  assign bus.mem_addr = pc;
  assign bus.mem_rd   = w_mem_rd;
  assign bus.cpu_in   = r_cpu_in;
  assign bus.cpu_load = w_load;
  assign bus.cpu_s    = w_start;

  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted = (r_state == S_HALT);

endmodule : instr_fetch_seq

// File: tb/tb_instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_seq
// Directed bench for instr_fetch_seq: synchronous instruction memory model,
// cpu handshake model (w falls one cycle after s, rises three cycles later),
// and a scoreboard of expected cpu_in values queued at each memory read.
// ----------------------------------------------------------------------------
module tb_instr_fetch_seq;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          stop;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [15:0]   instr_count;

  instr_fetch_seq_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_seq #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .HALT_OP  (3'b111),
    .PC_RESET (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .stop        (stop),
    .bus         (bus.master),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_rd    = 0;
  int unsigned n_load  = 0;
  int unsigned n_s     = 0;
  int unsigned n_done  = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Synchronous instruction memory
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // cpu model: w drops one cycle after s, rises three cycles after that
  int unsigned ph = 0;
  always @(negedge clk) begin
    if (bus.cpu_s) begin
      ph = 1;
    end else if (ph == 1) begin
      bus.cpu_w = 1'b0;
      ph = 2;
    end else if (ph == 2 || ph == 3) begin
      ph = ph + 1;
    end else if (ph == 4) begin
      bus.cpu_w = 1'b1;
      n_done++;
      ph = 0;
    end
  end

  // Monitor / scoreboard
  logic          s_prev = 1'b0;
  logic [AW-1:0] s_pc   = '0;
  always @(negedge clk) begin
    if (bus.cpu_load) begin
      n_load++;
      if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("sb_cpu_in", bus.cpu_in, exp_q.pop_front());
    end
    if (bus.cpu_load || bus.cpu_s) chk("load_s_excl", bus.cpu_load & bus.cpu_s, 1'b0);
    if (bus.mem_rd) begin
      n_rd++;
      if (mem[bus.mem_addr][15:13] != 3'b111) exp_q.push_back(mem[bus.mem_addr]);
    end
    if (s_prev) chk("pc_incr", pc, 8'(s_pc + 8'd1));
    if (bus.cpu_s) n_s++;
    s_prev = bus.cpu_s;
    s_pc   = pc;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int unsigned base;
  int unsigned rd0;
  int unsigned ld0;

  initial begin
    reset = 1'b1; go = 1'b0; stop = 1'b0; bus.cpu_w = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'hD105;
    mem[1] = 16'hE000;

    // ---- reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_pc", pc, 8'h00);
    chk("rst_cpu_in", bus.cpu_in, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_count", instr_count, 16'h0000);
    chk("rst_strobes", {bus.mem_rd, bus.cpu_load, bus.cpu_s}, 3'b000);
    repeat (3) @(negedge clk);
    chk("idle_no_rd", n_rd, 0);

    // ---- single instruction followed by HALT
    go = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t3_load", bus.cpu_load, 1'b1);
    chk("t3_s", bus.cpu_s, 1'b0);
    chk("t3_cpu_in", bus.cpu_in, 16'hD105);
    @(posedge clk); #1;
    chk("t4_s", bus.cpu_s, 1'b1);
    chk("t4_load", bus.cpu_load, 1'b0);
    @(posedge clk); #1;
    chk("t5_pc", pc, 8'h01);
    repeat (4) @(posedge clk); #1;
    chk("fetch1_rd", bus.mem_rd, 1'b1);
    chk("fetch1_addr", bus.mem_addr, 8'h01);
    chk("fetch1_count", instr_count, 16'd1);
    repeat (2) @(posedge clk); #1;
    chk("halt_halted", halted, 1'b1);
    chk("halt_busy", busy, 1'b0);
    chk("halt_pc", pc, 8'h01);
    chk("halt_count", instr_count, 16'd1);
    chk("halt_nload", n_load, 1);
    chk("halt_ns", n_s, 1);
    rd0 = n_rd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); go = ~go;
    end
    @(negedge clk);
    chk("halt_sticky", halted, 1'b1);
    chk("halt_no_rd", n_rd, rd0);
    chk("halt_nload2", n_load, 1);

    // ---- stop mid-run
    @(negedge clk); reset = 1'b1; go = 1'b0; exp_q.delete();
    mem[0] = 16'h1000; mem[1] = 16'h1001;
    @(negedge clk); reset = 1'b0;
    chk("rst2_halted", halted, 1'b0);
    go = 1'b1;
    for (int k = 0; k < 200 && !(bus.cpu_s && pc == 8'h02); k++) @(negedge clk);
    chk("stop_reach_pc2", {bus.cpu_s, pc}, {1'b1, 8'h02});
    @(negedge clk); stop = 1'b1;
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    chk("stop_idle", {busy, halted}, 2'b00);
    chk("stop_count", instr_count, 16'd3);
    chk("stop_pc", pc, 8'h03);
    rd0 = n_rd;
    repeat (10) @(negedge clk);
    chk("stop_no_rd", n_rd, rd0);
    chk("stop_count_hold", instr_count, 16'd3);

    // ---- reset mid-handshake (WAIT_DONE with w low)
    stop = 1'b0;
    for (int k = 0; k < 50 && bus.cpu_w; k++) @(negedge clk);
    chk("mh_w_low", bus.cpu_w, 1'b0);
    @(negedge clk);
    chk("mh_busy", busy, 1'b1);
    reset = 1'b1; go = 1'b0; exp_q.delete();
    @(posedge clk); #1;
    chk("mh_busy_rst", busy, 1'b0);
    chk("mh_pc", pc, 8'h00);
    chk("mh_count", instr_count, 16'd0);
    chk("mh_strobes", {bus.cpu_load, bus.cpu_s}, 2'b00);
    @(negedge clk); reset = 1'b0;
    ld0 = n_load;
    repeat (8) @(negedge clk);
    chk("mh_no_load", n_load, ld0);

    // ---- saturation and pc wrap
    force dut.u_fetch_pc.r_instr_count = 16'hFFFE;
    #1;
    release dut.u_fetch_pc.r_instr_count;
    go = 1'b1;
    base = n_done;
    for (int k = 0; k < 100 && n_done < base + 2; k++) @(negedge clk);
    @(negedge clk);
    chk("sat_ffff", instr_count, 16'hFFFF);
    for (int k = 0; k < 100 && n_done < base + 3; k++) @(negedge clk);
    @(negedge clk);
    chk("sat_hold", instr_count, 16'hFFFF);
    for (int k = 0; k < 3000 && !(bus.cpu_s && pc == 8'hFF); k++) @(negedge clk);
    chk("wrap_reach_ff", {bus.cpu_s, pc}, {1'b1, 8'hFF});
    @(negedge clk);
    chk("wrap_pc", pc, 8'h00);
    go = 1'b0;
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    chk("end_idle", busy, 1'b0);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_instr_fetch_seq
